alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
Initiator-side front end for the team's clocked Alu (PARITY/POPCOUNT/ROTR/ROTL).
- Accepts one operation request over a valid/ready interface.
- Drives the Alu opcode/A_in/B_in ports from registers.
- Waits a fixed Alu latency, captures Alu_out and returns it over a valid/ready response interface.
- Sits between a command source (sequencer/CPU shim) and the Alu, replacing hand-timed bench stimulus.

Parameters:
- DATA_WIDTH, 1024, operand/result width; must match the Alu instance.
- ALU_LATENCY, 1, edges from alu_* operands changing to Alu_out valid; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_opcode  in  3  0=PARITY, 1=POPCOUNT, 2=ROTR, 3=ROTL, 4..7 illegal
- req_a  in  DATA_WIDTH  operand A
- req_b  in  DATA_WIDTH  operand B (rotate amount for ROTR/ROTL)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  DATA_WIDTH  captured Alu result
- rsp_err  out  1  request had an illegal opcode
- alu_opcode  out  3  to Alu opcode
- alu_a  out  DATA_WIDTH  to Alu A_in
- alu_b  out  DATA_WIDTH  to Alu B_in
- alu_out  in  DATA_WIDTH  from Alu Alu_out
- busy  out  1  high whenever state is not IDLE

Behaviour:
- One clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, alu_opcode=0, alu_a=0, alu_b=0, latency counter=0.
- Combinational outputs: req_ready = (state==IDLE), so 1 in and after reset. busy = (state!=IDLE), so 0.
- FSM states:
  - IDLE: on req_valid && req_ready at edge E0:
    - Legal opcode (0..3): load alu_opcode/alu_a/alu_b from req_*, load counter with ALU_LATENCY, go WAIT.
    - Illegal opcode (4..7): alu_* unchanged, set rsp_err=1 and rsp_data=0, go RESP. The response is valid after E0.
  - WAIT: at each edge, if counter != 0, decrement it. If counter == 0, capture alu_out into rsp_data, set rsp_err=0 and rsp_valid=1, and go RESP.
  - RESP: hold rsp_valid/rsp_data/rsp_err stable while rsp_ready=0. On the edge with rsp_ready=1, clear rsp_valid and return to IDLE. rsp_data keeps its last value.
- Latency: a legal request accepted at edge E0 gives rsp_valid high after edge E0+ALU_LATENCY+1. With ALU_LATENCY=1 that is 2 cycles.
- Throughput: no overlap. A new request is accepted no earlier than the cycle after the response handshake, giving a minimum of ALU_LATENCY+3 cycles per op.
- alu_* ports hold the last issued operands until the next legal accept; they never change in WAIT or RESP.
- req_* are ignored when req_ready=0, including req_valid asserted during WAIT or RESP.
- Reset asserted mid-operation (WAIT or RESP) immediately clears all state. The in-flight op is dropped with no response.
- rsp_ready asserted while rsp_valid=0 has no effect.

Test Plan:
- PARITY, a=8'b10101101 zero-extended, b=same, Alu with ALU_LATENCY=1; accept at edge N -> rsp_valid high after edge N+2, rsp_data=1, rsp_err=0. Repeat with a=8'b10101100 -> rsp_data=0.
- POPCOUNT, a=8'b11101101 -> rsp_data=6. Then back-to-back POPCOUNT a=8'b10101101 with req_valid held high -> second accepted only once back in IDLE, rsp_data=5.
- ROTR, a=8'hAD, b=3 -> rsp_data={3'b101,1021'h15}. ROTL, a={8'hAD,1016'b0}, b=3 -> rsp_data={5'b01101,1016'b0,3'b101}.
- Illegal opcode 3'b110, a=8'hFF -> rsp_valid after 1 edge, rsp_err=1, rsp_data=0, alu_opcode/alu_a unchanged from the previous op.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_err stable, req_ready=0 and busy=1 throughout. rsp_ready=1 -> next edge rsp_valid=0, req_ready=1.
- Reset mid-WAIT (use ALU_LATENCY=4, drop rst_n 2 edges after accept) -> all outputs immediately at reset values. After release, no rsp_valid ever appears for the dropped op, and the next request completes normally.

Source files
------------

// File: rtl/alu_op_issuer.sv
// alu_op_issuer
//   Initiator-side front end for the clocked Alu (PARITY/POPCOUNT/ROTR/ROTL).
//   Takes one request over valid/ready and drives the Alu operands from registers.
//   It then waits a fixed Alu latency, captures the result and returns it over
//   a valid/ready response channel. Operations never overlap.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_opcode/req_a/req_b request opcode (0..3 legal) and operands
//   rsp_valid/rsp_ready    response handshake
//   rsp_data/rsp_err       captured Alu result / illegal-opcode flag
//   alu_opcode/alu_a/alu_b registered operands to the Alu
//   alu_out                Alu result
//   busy                   high whenever not IDLE
//
// State table
//   state   | meaning
//   IDLE    | ready for a request
//   WAIT    | operands issued, counting down the Alu latency
//   RESP    | response held until rsp_ready
module alu_op_issuer #(
  parameter int DATA_WIDTH  = 1024,
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_opcode,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [2:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY);

  logic [1:0] state;
  logic [3:0] lat_cnt;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            // opcodes 4..7 have bit 2 set; they never reach the Alu
            if (!req_opcode[2]) begin
              alu_opcode <= req_opcode;
              alu_a      <= req_a;
              alu_b      <= req_b;
              lat_cnt    <= LAT_LOAD;
              state      <= ST_WAIT;
            end else begin
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          // one extra edge after the count reaches zero gives the Alu its full latency
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            rsp_data  <= alu_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
module tb_alu_op_issuer;
  localparam int DW = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n      [2];
  logic          req_valid  [2];
  logic          req_ready  [2];
  logic [2:0]    req_opcode;
  logic [DW-1:0] req_a, req_b;
  logic          rsp_valid  [2];
  logic          rsp_ready  [2];
  logic [DW-1:0] rsp_data   [2];
  logic          rsp_err    [2];
  logic [2:0]    alu_opcode [2];
  logic [DW-1:0] alu_a      [2];
  logic [DW-1:0] alu_b      [2];
  logic [DW-1:0] alu_out    [2];
  logic          busy       [2];

  alu_op_issuer #(.DATA_WIDTH(DW), .ALU_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .alu_opcode(alu_opcode[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .alu_out(alu_out[0]), .busy(busy[0])
  );

  alu_op_issuer #(.DATA_WIDTH(DW), .ALU_LATENCY(4)) dut_l4 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .alu_opcode(alu_opcode[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .alu_out(alu_out[1]), .busy(busy[1])
  );

  // Behavioural Alu: result appears ALU_LATENCY edges after operands change.
  function automatic logic [DW-1:0] alu_f(logic [2:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    int s;
    s = int'(b[9:0]);
    case (op)
      3'd0:    return {{(DW-1){1'b0}}, ^a};
      3'd1:    return DW'($countones(a));
      3'd2:    return (a >> s) | (a << (DW - s));
      3'd3:    return (a << s) | (a >> (DW - s));
      default: return '0;
    endcase
  endfunction

  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe4 [4];
  always_ff @(posedge clk) begin
    pipe1    <= alu_f(alu_opcode[0], alu_a[0], alu_b[0]);
    pipe4[0] <= alu_f(alu_opcode[1], alu_a[1], alu_b[1]);
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
    pipe4[3] <= pipe4[2];
  end
  assign alu_out[0] = pipe1;
  assign alu_out[1] = pipe4[3];

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
    logic          err;
    int            hold;
  } vec_t;
  vec_t vecs[6];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h",
               name, act[DW-1:DW-32], act[63:0], exp[DW-1:DW-32], exp[63:0]);
    end
  endtask

  task automatic chk_reset(int d, string tag);
    chk({tag, " rsp_valid"},  DW'(rsp_valid[d]), '0);
    chk({tag, " rsp_data"},   rsp_data[d], '0);
    chk({tag, " rsp_err"},    DW'(rsp_err[d]), '0);
    chk({tag, " alu_opcode"}, DW'(alu_opcode[d]), '0);
    chk({tag, " alu_a"},      alu_a[d], '0);
    chk({tag, " alu_b"},      alu_b[d], '0);
    chk({tag, " req_ready"},  DW'(req_ready[d]), DW'(1));
    chk({tag, " busy"},       DW'(busy[d]), '0);
  endtask

  // Drive a request to DUT d, push its expectation, return #1 after the accept edge.
  task automatic issue(int d, logic [2:0] op, logic [DW-1:0] a, logic [DW-1:0] b,
                       logic [DW-1:0] exp_d, logic exp_e, bit hold_valid);
    exp_t e;
    int n;
    e.data = exp_d;
    e.err  = exp_e;
    e.lat  = exp_e ? 0 : ((d == 0) ? 2 : 5);
    sb.push_back(e);
    @(negedge clk);
    req_opcode   = op;
    req_a        = a;
    req_b        = b;
    req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue timeout: req_ready never high on dut %0d", d);
    end
    @(posedge clk);
    #1;
    if (!hold_valid) req_valid[d] = 1'b0;
  endtask

  // Wait for the response, compare with scoreboard, optionally backpressure, then handshake.
  task automatic collect(int d, int hold, string name);
    exp_t e;
    int cnt;
    logic [DW-1:0] d0;
    logic e0;
    cnt = 0;
    @(negedge clk);
    while (!rsp_valid[d] && cnt < 60) begin
      cnt++;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty at response", name);
      return;
    end
    e = sb.pop_front();
    chk({name, " latency"}, DW'(cnt), DW'(e.lat));
    chk({name, " data"}, rsp_data[d], e.data);
    chk({name, " err"}, DW'(rsp_err[d]), DW'(e.err));
    d0 = rsp_data[d];
    e0 = rsp_err[d];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({name, " bp valid"}, DW'(rsp_valid[d]), DW'(1));
      chk({name, " bp data"}, rsp_data[d], d0);
      chk({name, " bp err"}, DW'(rsp_err[d]), DW'(e0));
      chk({name, " bp req_ready"}, DW'(req_ready[d]), '0);
      chk({name, " bp busy"}, DW'(busy[d]), DW'(1));
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk({name, " post valid"}, DW'(rsp_valid[d]), '0);
    chk({name, " post req_ready"}, DW'(req_ready[d]), DW'(1));
    chk({name, " post data kept"}, rsp_data[d], d0);
  endtask

  initial begin
    logic [2:0]    prev_op;
    logic [DW-1:0] prev_a, prev_b;
    int            seen;

    vecs[0] = '{op: 3'd0, a: DW'(8'hAD), b: DW'(8'hAD), exp: DW'(1), err: 1'b0, hold: 0};
    vecs[1] = '{op: 3'd0, a: DW'(8'hAC), b: DW'(8'hAC), exp: DW'(0), err: 1'b0, hold: 0};
    vecs[2] = '{op: 3'd1, a: DW'(8'hED), b: DW'(0), exp: DW'(6), err: 1'b0, hold: 0};
    vecs[3] = '{op: 3'd2, a: DW'(8'hAD), b: DW'(3), exp: {3'b101, 1021'h15}, err: 1'b0, hold: 5};
    vecs[4] = '{op: 3'd3, a: {8'hAD, 1016'b0}, b: DW'(3),
                exp: {5'b01101, 1016'b0, 3'b101}, err: 1'b0, hold: 0};
    vecs[5] = '{op: 3'd1, a: {DW{1'b1}}, b: DW'(0), exp: DW'(1024), err: 1'b0, hold: 0};

    rst_n[0] = 1'b0;  rst_n[1] = 1'b0;
    req_valid[0] = 1'b0;  req_valid[1] = 1'b0;
    rsp_ready[0] = 1'b0;  rsp_ready[1] = 1'b0;
    req_opcode = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(negedge clk);
    chk_reset(0, "reset l1");
    chk_reset(1, "reset l4");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    for (int i = 0; i < 6; i++) begin
      issue(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].err, 1'b0);
      collect(0, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Illegal opcode: immediate error response, Alu operands untouched.
    prev_op = alu_opcode[0];
    prev_a  = alu_a[0];
    prev_b  = alu_b[0];
    issue(0, 3'b110, DW'(8'hFF), DW'(0), '0, 1'b1, 1'b0);
    collect(0, 2, "illegal");
    chk("illegal alu_opcode kept", DW'(alu_opcode[0]), DW'(prev_op));
    chk("illegal alu_a kept", alu_a[0], prev_a);
    chk("illegal alu_b kept", alu_b[0], prev_b);

    // Back-to-back with req_valid held: second op waits for IDLE.
    issue(0, 3'd1, DW'(8'hED), DW'(0), DW'(6), 1'b0, 1'b1);
    req_a = DW'(8'hAD);
    sb.push_back('{data: DW'(5), err: 1'b0, lat: 2});
    collect(0, 2, "b2b first");
    chk("b2b alu_a held", alu_a[0], DW'(8'hED));
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    collect(0, 0, "b2b second");
    chk("b2b alu_a second", alu_a[0], DW'(8'hAD));

    // Reset during WAIT on the latency-4 instance: op is dropped.
    issue(1, 3'd2, DW'(8'hAD), DW'(3), {3'b101, 1021'h15}, 1'b0, 1'b0);
    void'(sb.pop_back());
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midwait busy", DW'(busy[1]), DW'(1));
    rst_n[1] = 1'b0;
    #1;
    chk_reset(1, "midwait reset");
    @(negedge clk);
    rst_n[1] = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid[1]) seen++;
    end
    chk("dropped op no response", DW'(seen), '0);
    issue(1, 3'd1, DW'(8'hED), DW'(0), DW'(6), 1'b0, 1'b0);
    collect(1, 0, "after reset l4");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
